free_list_alloc: RTL and testbench

FREE_LIST_ALLOC -- requirements
Module: free_list_alloc

---
 rtl/free_list_alloc.sv | 132 +++++++++++++
 tb/tb_free_list_alloc.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/free_list_alloc.sv
// Circular free list of physical register tags for a multi-lane rename stage.
// Define FREELIST_CHECK_EN to build the sticky overflow / commit-overrun fault detector.
module free_list_alloc #(
    parameter int ALLOC_W  = 4,
    parameter int FREE_W   = 4,
    parameter int PHY_REGS = 96,
    parameter int LOG_REGS = 34,
    parameter int PHY_IDX  = 7
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            reqValid_i,
    input  logic [2:0]                      reqCount_i,
    output logic [ALLOC_W-1:0][PHY_IDX-1:0] freeTag_o,
    output logic                            stall_o,
    input  logic [FREE_W-1:0]               freeVec_i,
    input  logic [FREE_W-1:0][PHY_IDX-1:0]  freeTagIn_i,
    input  logic [2:0]                      commitAlloc_i,
    input  logic                            recoverFlag_i,
    output logic [PHY_IDX-1:0]              count_o,
    output logic                            error_o
);
    localparam int DEPTH = PHY_REGS - LOG_REGS;
    localparam int PTR_W = $clog2(DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;

    logic [PHY_IDX-1:0] buffer [DEPTH];
    ptr_t               head;
    ptr_t               tail;
    ptr_t               commit_head;
    logic [PHY_IDX-1:0] count;

    ptr_t               head_nxt;
    ptr_t               commit_nxt;
    ptr_t               tail_nxt;
    logic [PHY_IDX-1:0] count_nxt;
    logic [2:0]         alloc_n;
    logic [FREE_W-1:0]  wr_en;
    ptr_t               wr_addr [FREE_W];
    int unsigned        accepted;
    int unsigned        base_occ;
`ifdef FREELIST_CHECK_EN
    logic               overflow;
    logic               overrun;
    logic               error_q;
`endif

    function automatic ptr_t ptr_add(input ptr_t p, input int unsigned inc);
        int unsigned s;
        s = 32'(p) + inc;
        if (s >= DEPTH) s = s - DEPTH;
        return ptr_t'(s);
    endfunction

    function automatic int unsigned ptr_dist(input ptr_t from, input ptr_t to);
        if (to >= from) return 32'(to) - 32'(from);
        return 32'(to) + DEPTH - 32'(from);
    endfunction

    always_comb begin
        for (int k = 0; k < ALLOC_W; k++) begin
            freeTag_o[k] = buffer[ptr_add(head, k)];
        end
    end

    assign stall_o = reqValid_i && (PHY_IDX'(reqCount_i) > count);
    assign count_o = count;

    always_comb begin
        alloc_n    = (reqValid_i && !stall_o && !recoverFlag_i) ? reqCount_i : 3'd0;
        commit_nxt = ptr_add(commit_head, 32'(commitAlloc_i));
        head_nxt   = recoverFlag_i ? commit_nxt : ptr_add(head, 32'(alloc_n));
        // On a flush the speculatively allocated tags between the new head and the old head come back.
        base_occ   = recoverFlag_i ? 32'(count) + ptr_dist(commit_nxt, head) : 32'(count);
        accepted   = 0;
        wr_en      = '0;
`ifdef FREELIST_CHECK_EN
        overflow   = 1'b0;
        overrun    = 32'(commitAlloc_i) > ptr_dist(commit_head, head);
`endif
        for (int i = 0; i < FREE_W; i++) begin
            wr_addr[i] = ptr_add(tail, accepted);
            if (freeVec_i[i]) begin
`ifdef FREELIST_CHECK_EN
                if (base_occ + accepted < DEPTH) begin
                    wr_en[i] = 1'b1;
                    accepted = accepted + 1;
                end else begin
                    overflow = 1'b1;
                end
`else
                wr_en[i] = 1'b1;
                accepted = accepted + 1;
`endif
            end
        end
        tail_nxt = ptr_add(tail, accepted);
        if (recoverFlag_i) count_nxt = PHY_IDX'(base_occ + accepted);
        else               count_nxt = PHY_IDX'(32'(count) + accepted - 32'(alloc_n));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head        <= '0;
            tail        <= '0;
            commit_head <= '0;
            count       <= PHY_IDX'(DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                buffer[i] <= PHY_IDX'(LOG_REGS + i);
            end
        end else begin
            head        <= head_nxt;
            tail        <= tail_nxt;
            commit_head <= commit_nxt;
            count       <= count_nxt;
            for (int i = 0; i < FREE_W; i++) begin
                if (wr_en[i]) buffer[wr_addr[i]] <= freeTagIn_i[i];
            end
        end
    end

`ifdef FREELIST_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                error_q <= 1'b0;
        else if (overflow || overrun) error_q <= 1'b1;
    end
    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_free_list_alloc.sv
// Directed scoreboard bench for free_list_alloc; expectations queued by the driver, checked by a monitor.
module tb_free_list_alloc;
    localparam int ALLOC_W = 4;
    localparam int FREE_W  = 4;
    localparam int PHY_IDX = 7;
`ifdef FREELIST_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic                            clk = 1'b0;
    logic                            reset_n = 1'b1;
    logic                            reqValid_i;
    logic [2:0]                      reqCount_i;
    logic [ALLOC_W-1:0][PHY_IDX-1:0] freeTag_o;
    logic                            stall_o;
    logic [FREE_W-1:0]               freeVec_i;
    logic [FREE_W-1:0][PHY_IDX-1:0]  freeTagIn_i;
    logic [2:0]                      commitAlloc_i;
    logic                            recoverFlag_i;
    logic [PHY_IDX-1:0]              count_o;
    logic                            error_o;

    free_list_alloc dut (
        .clk(clk), .reset_n(reset_n), .reqValid_i(reqValid_i), .reqCount_i(reqCount_i),
        .freeTag_o(freeTag_o), .stall_o(stall_o), .freeVec_i(freeVec_i),
        .freeTagIn_i(freeTagIn_i), .commitAlloc_i(commitAlloc_i),
        .recoverFlag_i(recoverFlag_i), .count_o(count_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    cnt;
        int    stall;
        int    err;
        int    tag [4];
    } exp_t;

    exp_t sb [$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic cmp(input string nm, input string field, input int act, input int req);
        if (req < 0) return;
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s.%s: got %0d, expected %0d", nm, field, act, req);
        end
    endtask

    // Monitor: outputs are combinational from the state reached at the previous edge plus current inputs.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.name, "count", int'(count_o), e.cnt);
            cmp(e.name, "stall", int'(stall_o), e.stall);
            cmp(e.name, "error", int'(error_o), e.err);
            for (int k = 0; k < ALLOC_W; k++) begin
                cmp(e.name, $sformatf("tag%0d", k), int'(freeTag_o[k]), e.tag[k]);
            end
        end
    end

    task automatic expect_out(input string nm, input int c, input int s, input int er,
                              input int t0, input int t1, input int t2, input int t3);
        exp_t e;
        e.name = nm; e.cnt = c; e.stall = s; e.err = er;
        e.tag[0] = t0; e.tag[1] = t1; e.tag[2] = t2; e.tag[3] = t3;
        sb.push_back(e);
    endtask

    task automatic drive(input logic rv, input logic [2:0] rc, input logic [3:0] fv,
                         input logic [6:0] f0, input logic [6:0] f1, input logic [6:0] f2,
                         input logic [6:0] f3, input logic [2:0] ca, input logic rec);
        reqValid_i = rv; reqCount_i = rc; freeVec_i = fv;
        freeTagIn_i[0] = f0; freeTagIn_i[1] = f1; freeTagIn_i[2] = f2; freeTagIn_i[3] = f3;
        commitAlloc_i = ca; recoverFlag_i = rec;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 3'd0, 1'b0);
    endtask

    task automatic alloc(input logic [2:0] n);
        drive(1'b1, n, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 3'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b1, 3'd4, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 3'd0, 1'b0);
        #1;
        expect_out("reset", 62, -1, 0, 34, 35, 36, 37);
        tick();
        idle();
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        do_reset();
        expect_out("post_reset", 62, 0, 0, 34, 35, 36, 37);
        tick();

        // Drain to two entries, then a stalled and a granted request.
        for (int i = 0; i < 15; i++) begin
            alloc(3'd4);
            expect_out($sformatf("alloc4_%0d", i), 62 - 4 * i, 0, 0, 34 + 4 * i, 35 + 4 * i, -1, -1);
            tick();
        end
        alloc(3'd3);
        expect_out("stall3", 2, 1, 0, 94, 95, 34, 35);
        tick();
        alloc(3'd2);
        expect_out("grant2", 2, 0, 0, 94, 95, -1, -1);
        tick();

        // Release into an empty list; same-cycle request must stall.
        drive(1'b1, 3'd1, 4'b1010, 7'd0, 7'd50, 7'd0, 7'd60, 3'd0, 1'b0);
        expect_out("rel_stall", 0, 1, 0, 34, -1, -1, -1);
        tick();
        idle();
        expect_out("rel_read", 2, 0, 0, 50, 60, -1, -1);
        tick();
        alloc(3'd2);
        expect_out("rel_grant", 2, 0, 0, 50, 60, -1, -1);
        tick();
        idle();
        expect_out("rel_empty", 0, 0, 0, -1, -1, -1, -1);
        tick();

        // Head wrap: 61 allocations, 3 releases, then 4 more.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            alloc(3'd4);
            tick();
        end
        alloc(3'd1);
        expect_out("a61", 2, 0, 0, 94, 95, 34, 35);
        tick();
        drive(1'b0, 3'd0, 4'b0111, 7'd70, 7'd71, 7'd72, 7'd0, 3'd0, 1'b0);
        expect_out("rel3", 1, 0, 0, 95, 34, 35, 36);
        tick();
        alloc(3'd4);
        expect_out("wrap", 4, 0, 0, 95, 70, 71, 72);
        tick();
        alloc(3'd1);
        expect_out("wrap_after", 0, 1, 0, 37, 38, 39, 40);
        tick();

        // Commit 3 of 8, then flush with an ignored request.
        do_reset();
        alloc(3'd4);
        expect_out("c_a0", 62, 0, 0, 34, -1, -1, -1);
        tick();
        alloc(3'd4);
        expect_out("c_a1", 58, 0, 0, 38, -1, -1, -1);
        tick();
        drive(1'b0, 3'd0, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 3'd3, 1'b0);
        expect_out("commit3", 54, 0, 0, 42, 43, -1, -1);
        tick();
        drive(1'b1, 3'd4, 4'b0000, 7'd0, 7'd0, 7'd0, 7'd0, 3'd0, 1'b1);
        expect_out("recover", 54, 0, 0, 42, -1, -1, -1);
        tick();
        alloc(3'd1);
        expect_out("rec_after", 59, 0, 0, 37, 38, 39, 40);
        tick();
        idle();
        expect_out("rec_alloc", 58, 0, 0, 38, -1, -1, -1);
        tick();

        // Release into a full list.
        do_reset();
        drive(1'b0, 3'd0, 4'b0001, 7'd99, 7'd0, 7'd0, 7'd0, 3'd0, 1'b0);
        expect_out("ovf_pre", 62, 0, 0, 34, -1, -1, -1);
        tick();
        idle();
        expect_out("ovf_err", CHK ? 62 : -1, 0, CHK, CHK ? 34 : -1, -1, -1, -1);
        tick();
        expect_out("ovf_hold", -1, 0, CHK, -1, -1, -1, -1);
        tick();
        do_reset();
        tick();

        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
